// File: rtl/ps2_cmd_pkg.sv
// Shared types and constants for the PS/2 scan-code to game-command decoder.
package ps2_cmd_pkg;

    localparam int unsigned NUM_CMDS = 6;
    localparam int unsigned CMD_W    = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_LEFT      = 3'd0,
        CMD_RIGHT     = 3'd1,
        CMD_ROTATE    = 3'd2,
        CMD_SOFT_DROP = 3'd3,
        CMD_HARD_DROP = 3'd4,
        CMD_PAUSE     = 3'd5
    } cmd_e;

    // Scan-code set 2 prefixes and the keys of interest
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_P     = 8'h4D;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    typedef struct packed {
        logic hit;
        cmd_e cmd;
    } key_hit_t;

    // Map a final scan code to a command; arrow keys match with or without E0,
    // space and P only without it.
    function automatic key_hit_t decode_key(input logic [7:0] code, input logic ext);
        key_hit_t r;
        r.hit = 1'b1;
        r.cmd = CMD_LEFT;
        case (code)
            SC_LEFT:  r.cmd = CMD_LEFT;
            SC_RIGHT: r.cmd = CMD_RIGHT;
            SC_UP:    r.cmd = CMD_ROTATE;
            SC_DOWN:  r.cmd = CMD_SOFT_DROP;
            SC_SPACE: begin
                r.cmd = CMD_HARD_DROP;
                r.hit = ~ext;
            end
            SC_P: begin
                r.cmd = CMD_PAUSE;
                r.hit = ~ext;
            end
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small command FIFO with a registered head entry and valid/ready read side.
module cmd_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             valid_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic             full;
    logic             pop;
    logic             do_push;

    // Handshake decode and next occupancy / next head entry
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        pop     = valid_q & ready_i;
        do_push = push_i & (~full | pop);
        rd_next = rd_ptr_q + PTR_W'(1);
        count_d = count_q;
        head_d  = head_q;
        if (do_push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (pop) begin
            // Next head is the following stored entry, or the incoming one when only one was held
            if (count_q >= CNT_W'(2)) begin
                head_d = mem_q[rd_next];
            end else if (do_push) begin
                head_d = wdata_i;
            end
        end else if (do_push && count_q == '0) begin
            head_d = wdata_i;
        end
    end

    // Storage array; contents are qualified by the pointers so it needs no reset
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_next;
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
            head_q  <= head_d;
        end
    end

    assign valid_o = valid_q;
    assign rdata_o = head_q;
    assign full_o  = full;
    assign count_o = count_q;

endmodule

// File: rtl/ps2_key_cmd_decoder.sv
// PS/2 scan-code stream to Tetris command queue with held-key tracking.
module ps2_key_cmd_decoder
    import ps2_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned PREFIX_TIMEOUT   = 500000,
    parameter int unsigned SOFT_DROP_REPEAT = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_key_pressed,
    input  logic [7:0]                    ps2_key_data,
    input  logic                          cmd_ready,
    output logic                          cmd_valid,
    output logic [CMD_W-1:0]              cmd_code,
    output logic [NUM_CMDS-1:0]           held,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned TMO_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREFIX_TIMEOUT - 1);

    dec_state_e          state_q, state_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [NUM_CMDS-1:0] held_q, held_d;
    logic                ovf_q, ovf_d;
    logic                ext;
    logic                brk;
    key_hit_t            key;
    logic [NUM_CMDS-1:0] key_oh;
    logic                push;
    logic                pop;
    logic                fifo_full;

    // Prefix tracking, make/break classification, repeat filter and timeout
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        held_d  = held_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        ext     = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        brk     = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        key     = decode_key(ps2_key_data, ext);
        key_oh  = NUM_CMDS'(1) << key.cmd;
        pop     = cmd_valid & cmd_ready;
        if (ps2_key_pressed) begin
            if (ps2_key_data == SC_EXT) begin
                state_d = ST_EXT;
            end else if (ps2_key_data == SC_BRK) begin
                state_d = ext ? ST_EXT_BRK : ST_BRK;
            end else begin
                state_d = ST_IDLE;
                if (key.hit) begin
                    if (brk) begin
                        held_d = held_q & ~key_oh;
                    end else if ((held_q & key_oh) == '0) begin
                        held_d = held_q | key_oh;
                        push   = 1'b1;
                    end else if (key.cmd == CMD_SOFT_DROP && SOFT_DROP_REPEAT != 0) begin
                        push   = 1'b1;
                    end
                end
            end
        end else if (state_q != ST_IDLE) begin
            // A dangling prefix is abandoned after a quiet interval
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // Decoder state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            held_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            held_q  <= held_d;
            ovf_q   <= ovf_d;
        end
    end

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (key.cmd),
        .ready_i (cmd_ready),
        .valid_o (cmd_valid),
        .rdata_o (cmd_code),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign held     = held_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_cmd_decoder.sv
// Directed bench for ps2_key_cmd_decoder: vector table plus multi-cycle sequences.
module tb_ps2_key_cmd_decoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_key_pressed = 1'b0;
    logic [7:0] ps2_key_data = 8'h00;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [5:0] held;
    logic       overflow;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ps2_key_cmd_decoder #(
        .FIFO_DEPTH       (DEPTH),
        .PREFIX_TIMEOUT   (TMO),
        .SOFT_DROP_REPEAT (1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .cmd_ready       (cmd_ready),
        .cmd_valid       (cmd_valid),
        .cmd_code        (cmd_code),
        .held            (held),
        .overflow        (overflow),
        .fifo_count      (fifo_count)
    );

    typedef struct packed {
        logic [3:0]      n;
        logic [5:0][7:0] b;
        logic [2:0]      cnt;
        logic [2:0]      code;
        logic [5:0]      held;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [3:0] n,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                                input logic [2:0] cnt, input logic [2:0] code, input logic [5:0] h);
        vec_t v;
        v.n    = n;
        v.b    = {b5, b4, b3, b2, b1, b0};
        v.cnt  = cnt;
        v.code = code;
        v.held = h;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One-cycle strobe; returns on the falling edge after the sampling edge
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        ps2_key_pressed = 1'b1;
        ps2_key_data    = b;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Expect a given head entry, then pop it
    task automatic pop_check(input string name, input logic [2:0] exp);
        check({name, "_valid"}, 32'(cmd_valid), 32'd1);
        check({name, "_code"}, 32'(cmd_code), 32'(exp));
        cmd_ready = 1'b1;
        @(negedge clock);
        cmd_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_count"}, 32'(fifo_count), 32'd0);
        check({name, "_valid"}, 32'(cmd_valid), 32'd0);
        check({name, "_code"}, 32'(cmd_code), 32'd0);
        check({name, "_held"}, 32'(held), 32'd0);
        check({name, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        tbl[0]  = mk(2, 8'hE0, 8'h6B, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 6'h01);
        tbl[1]  = mk(5, 8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B, 8'h00, 1, 0, 6'h00);
        tbl[2]  = mk(5, 8'h75, 8'h75, 8'h75, 8'hF0, 8'h75, 8'h00, 1, 2, 6'h00);
        tbl[3]  = mk(3, 8'h72, 8'h72, 8'h72, 8'h00, 8'h00, 8'h00, 3, 3, 6'h08);
        tbl[4]  = mk(2, 8'hE0, 8'h29, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 6'h00);
        tbl[5]  = mk(5, 8'hAA, 8'hFA, 8'hE0, 8'hF0, 8'h12, 8'h00, 0, 0, 6'h00);
        tbl[6]  = mk(6, 8'hAA, 8'hFA, 8'hE0, 8'hF0, 8'h12, 8'h74, 1, 1, 6'h02);
        tbl[7]  = mk(1, 8'h29, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4, 6'h10);
        tbl[8]  = mk(3, 8'h4D, 8'hF0, 8'h4D, 8'h00, 8'h00, 8'h00, 1, 5, 6'h00);
        tbl[9]  = mk(2, 8'hE0, 8'h75, 8'h00, 8'h00, 8'h00, 8'h00, 1, 2, 6'h04);
        tbl[10] = mk(2, 8'hF0, 8'h6B, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 6'h00);
        tbl[11] = mk(2, 8'hE1, 8'h6B, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 6'h01);
        tbl[12] = mk(5, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h74, 8'h00, 0, 0, 6'h00);
        tbl[13] = mk(2, 8'h6B, 8'h74, 8'h00, 8'h00, 8'h00, 8'h00, 2, 0, 6'h03);

        // Reset state
        idle(2);
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("reset");

        // Table vectors, each from a fresh reset
        for (int t = 0; t < 14; t++) begin
            string nm;
            nm = $sformatf("vec%0d", t);
            do_reset();
            for (int i = 0; i < 6; i++) begin
                if (4'(i) < tbl[t].n) send_byte(tbl[t].b[i]);
            end
            check({nm, "_count"}, 32'(fifo_count), 32'(tbl[t].cnt));
            check({nm, "_held"}, 32'(held), 32'(tbl[t].held));
            check({nm, "_ovf"}, 32'(overflow), 32'd0);
            check({nm, "_valid"}, 32'(cmd_valid), 32'(tbl[t].cnt != 0));
            if (tbl[t].cnt != 0) check({nm, "_code"}, 32'(cmd_code), 32'(tbl[t].code));
        end

        // Soft-drop repeats drain as three code-3 entries
        do_reset();
        send_byte(8'h72); send_byte(8'h72); send_byte(8'h72);
        pop_check("sd0", 3'd3);
        pop_check("sd1", 3'd3);
        pop_check("sd2", 3'd3);
        check("sd_empty", 32'(cmd_valid), 32'd0);

        // Overflow: five makes into a four-deep queue
        do_reset();
        send_byte(8'h29); send_byte(8'hF0); send_byte(8'h29);
        send_byte(8'h4D); send_byte(8'hF0); send_byte(8'h4D);
        send_byte(8'h6B); send_byte(8'hF0); send_byte(8'h6B);
        send_byte(8'h74); send_byte(8'hF0); send_byte(8'h74);
        check("ovf_pre", 32'(overflow), 32'd0);
        send_byte(8'h75); send_byte(8'hF0); send_byte(8'h75);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_held", 32'(held), 32'd0);
        check("ovf_head", 32'(cmd_code), 32'd4);
        // Push and pop together while full
        @(negedge clock);
        ps2_key_pressed = 1'b1;
        ps2_key_data    = 8'h72;
        cmd_ready       = 1'b1;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
        cmd_ready       = 1'b0;
        check("pp_count", 32'(fifo_count), 32'd4);
        check("pp_ovf", 32'(overflow), 32'd1);
        check("pp_held", 32'(held), 32'h08);
        pop_check("dr0", 3'd5);
        pop_check("dr1", 3'd0);
        pop_check("dr2", 3'd1);
        pop_check("dr3", 3'd3);
        check("dr_count", 32'(fifo_count), 32'd0);
        check("dr_valid", 32'(cmd_valid), 32'd0);
        // Ready while empty does nothing
        cmd_ready = 1'b1;
        idle(2);
        cmd_ready = 1'b0;
        check("rdy_empty", 32'(fifo_count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Prefix abandoned after the timeout
        do_reset();
        send_byte(8'hE0);
        idle(TMO + 2);
        send_byte(8'h29);
        check("tmo_count", 32'(fifo_count), 32'd1);
        check("tmo_code", 32'(cmd_code), 32'd4);
        check("tmo_held", 32'(held), 32'h10);

        // Prefix still live shortly before the timeout
        do_reset();
        send_byte(8'hE0);
        idle(TMO - 4);
        send_byte(8'h29);
        check("notmo_count", 32'(fifo_count), 32'd0);
        check("notmo_held", 32'(held), 32'd0);

        // Reset in the middle of an extended break with entries queued
        do_reset();
        send_byte(8'h6B); send_byte(8'h74); send_byte(8'h75);
        check("mid_count", 32'(fifo_count), 32'd3);
        send_byte(8'hE0); send_byte(8'hF0);
        do_reset();
        check_all_zero("midrst");
        send_byte(8'h6B);
        check("post_count", 32'(fifo_count), 32'd1);
        check("post_code", 32'(cmd_code), 32'd0);
        check("post_held", 32'(held), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
